// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, FSM states, FIFO entry record.
package fetch_pkg;

  localparam int unsigned PC_WIDTH_DEF = 16;
  localparam int unsigned IR_WIDTH_DEF = 32;
  localparam int unsigned IMEM_AW_DEF  = 6;

  // RUN: issuing allowed; HOLD: FIFO occupancy plus in-flight request fill both slots
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  // One buffered instruction and the address it was fetched from
  typedef struct packed {
    logic [IR_WIDTH_DEF-1:0] ir;
    logic [PC_WIDTH_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry shift FIFO; entry 0 is always the head. Flush has priority over push/pop.
module fetch_fifo2
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  entry_t     din_i,
  output entry_t     head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  logic [1:0] count_q, count_d;
  entry_t     e0_q, e0_d;
  entry_t     e1_q, e1_d;
  logic       do_pop, do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Next-state for occupancy and storage under push/pop/flush
  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = din_i;
          else                 e1_d = din_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = din_i;
          end else begin
            e0_d = e1_q;
            e1_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign head_o  = e0_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, single-cycle imem, 2-entry output FIFO,
// redirect with epoch-tagged discard of stale responses.
// Optional statistics counters enabled by defining FETCH_STATS_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned          IR_WIDTH = IR_WIDTH_DEF,
  parameter int unsigned          IMEM_AW  = IMEM_AW_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [IR_WIDTH-1:0] imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IR_WIDTH-1:0] out_ir,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [PC_WIDTH-1:0] out_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [15:0]         flush_count
`endif
);

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(4);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  epoch_q;
  logic                  infl_q;
  logic                  infl_epoch_q;
  logic [PC_WIDTH-1:0]   infl_pc_q;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [1:0]            fifo_count, count_nxt, total_nxt;
  entry_t                din, head;

  assign pop  = out_valid && out_ready;
  assign push = infl_q && (infl_epoch_q == epoch_q);
  assign din  = '{ir: imem_rdata, pc: infl_pc_q};

  fetch_fifo2 #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .din_i   (din),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: HOLD exactly when next cycle's occupancy plus in-flight fills both slots
  always_comb begin
    count_nxt = fifo_count + {1'b0, push} - {1'b0, pop};
    total_nxt = count_nxt + {1'b0, imem_req};
    state_d   = (total_nxt == 2'd2) ? HOLD : RUN;
    if (rst || redirect_valid) begin
      count_nxt = '0;
      total_nxt = '0;
      state_d   = RUN;
    end
  end

  // FSM outputs: in HOLD a same-cycle pop frees the slot, keeping back-to-back throughput
  always_comb begin
    imem_req = !rst && !redirect_valid && ((state_q == RUN) || pop);
  end

  // Fetch PC, epoch and in-flight tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      epoch_q      <= 1'b0;
      infl_q       <= 1'b0;
      infl_epoch_q <= 1'b0;
      infl_pc_q    <= '0;
    end else begin
      infl_q <= imem_req;
      if (imem_req) begin
        infl_epoch_q <= epoch_q;
        infl_pc_q    <= pc_q;
      end
      if (redirect_valid) begin
        pc_q    <= redirect_pc;
        epoch_q <= ~epoch_q;
      end else if (imem_req) begin
        pc_q <= pc_q + PC_INC;
      end
    end
  end

  // Guard against overrunning the FIFO
  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_full && push && !pop));
  end

  assign imem_addr    = pc_q[IMEM_AW+1:2];
  assign out_valid    = !fifo_empty;
  assign out_ir       = fifo_empty ? '0 : head.ir;
  assign out_pc       = fifo_empty ? '0 : head.pc;
  assign out_pc_plus4 = fifo_empty ? '0 : head.pc + PC_INC;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [15:0] flush_count_q;

  // Saturating counters of non-void transfers and redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (pop && !redirect_valid && (fetch_count_q != '1))
        fetch_count_q <= fetch_count_q + 32'd1;
      if (redirect_valid && (flush_count_q != '1))
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
